// File: rtl/time_display_if.sv
// Bundle of the time_display data-side signals: seconds input, scanned
// 7-segment outputs and status flags.
interface time_display_if;
    logic [15:0] Time;
    logic [3:0]  an;
    logic [7:0]  seg;
    logic        ovf;
    logic        busy;

    modport master (output Time, input an, seg, ovf, busy);
    modport slave  (input Time, output an, seg, ovf, busy);
endinterface

// File: rtl/time_display.sv
// Binary seconds -> MM:SS BCD (sequential divide/clamp/double-dabble) feeding a
// 4-digit multiplexed 7-segment scanner. TIME_DISPLAY_LZB_EN blanks a zero minutes-tens digit.
module time_display #(
    parameter int unsigned SCAN_DIV = 100000
) (
    input  logic          clk,
    input  logic          rst,
    time_display_if.slave bus
);

    typedef enum logic [2:0] {S_IDLE, S_DIV, S_CLAMP, S_BCD, S_LOAD} state_t;

    localparam logic [19:0] SCAN_LAST = 20'(SCAN_DIV - 1);

    state_t      r_state, w_next;
    logic [15:0] r_last;
    logic [15:0] r_work;
    logic [5:0]  r_rem;
    logic [3:0]  r_cnt;
    logic [6:0]  r_min;
    logic [6:0]  r_sec;
    logic [7:0]  r_min_bcd;
    logic [7:0]  r_sec_bcd;
    logic        r_ovf_pend;
    logic [3:0]  r_dig [4];
    logic        r_ovf;

    logic [19:0] r_scan_cnt;
    logic [1:0]  r_idx;
    logic [3:0]  r_an;
    logic [7:0]  r_seg;

    logic        w_change;
    logic [6:0]  w_trial;
    logic        w_ge;
    logic [5:0]  w_diff;
    logic        w_big;
    logic [7:0]  w_min_adj;
    logic [7:0]  w_sec_adj;
    logic [3:0]  w_digit;
    logic [7:0]  w_seg_next;

    function automatic logic [3:0] add3(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    return 7'h3F;
            4'd1:    return 7'h06;
            4'd2:    return 7'h5B;
            4'd3:    return 7'h4F;
            4'd4:    return 7'h66;
            4'd5:    return 7'h6D;
            4'd6:    return 7'h7D;
            4'd7:    return 7'h07;
            4'd8:    return 7'h7F;
            4'd9:    return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    assign w_change = (bus.Time != r_last);

    // Restoring divide by 60: quotient bits shift into r_work as dividend bits leave it
    assign w_trial = {r_rem, r_work[15]};
    assign w_ge    = (w_trial >= 7'd60);
    assign w_diff  = w_trial[5:0] - 6'd60;
    assign w_big   = (r_work > 16'd99);

    assign w_min_adj = {add3(r_min_bcd[7:4]), add3(r_min_bcd[3:0])};
    assign w_sec_adj = {add3(r_sec_bcd[7:4]), add3(r_sec_bcd[3:0])};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_change) w_next = S_DIV;
            S_DIV:   if (r_cnt == 4'd15) w_next = S_CLAMP;
            S_CLAMP: w_next = S_BCD;
            S_BCD:   if (r_cnt == 4'd6) w_next = S_LOAD;
            S_LOAD:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        bus.busy = (r_state != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last     <= '0;
            r_work     <= '0;
            r_rem      <= '0;
            r_cnt      <= '0;
            r_min      <= '0;
            r_sec      <= '0;
            r_min_bcd  <= '0;
            r_sec_bcd  <= '0;
            r_ovf_pend <= 1'b0;
            r_ovf      <= 1'b0;
            for (int unsigned i = 0; i < 4; i++) r_dig[i] <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_change) begin
                        r_work <= bus.Time;
                        r_last <= bus.Time;
                        r_rem  <= '0;
                        r_cnt  <= '0;
                    end
                end
                S_DIV: begin
                    r_rem  <= w_ge ? w_diff : w_trial[5:0];
                    r_work <= {r_work[14:0], w_ge};
                    r_cnt  <= r_cnt + 4'd1;
                end
                S_CLAMP: begin
                    r_min      <= w_big ? 7'd99 : r_work[6:0];
                    r_sec      <= w_big ? 7'd59 : {1'b0, r_rem};
                    r_ovf_pend <= w_big;
                    r_min_bcd  <= '0;
                    r_sec_bcd  <= '0;
                    r_cnt      <= '0;
                end
                S_BCD: begin
                    r_min_bcd <= (w_min_adj << 1) | {7'd0, r_min[6]};
                    r_sec_bcd <= (w_sec_adj << 1) | {7'd0, r_sec[6]};
                    r_min     <= {r_min[5:0], 1'b0};
                    r_sec     <= {r_sec[5:0], 1'b0};
                    r_cnt     <= r_cnt + 4'd1;
                end
                S_LOAD: begin
                    r_dig[0] <= r_sec_bcd[3:0];
                    r_dig[1] <= r_sec_bcd[7:4];
                    r_dig[2] <= r_min_bcd[3:0];
                    r_dig[3] <= r_min_bcd[7:4];
                    r_ovf    <= r_ovf_pend;
                end
                default: ;
            endcase
        end
    end

    assign w_digit = r_dig[r_idx];

    always_comb begin
        w_seg_next = {(r_idx == 2'd2), seg7(w_digit)};
`ifdef TIME_DISPLAY_LZB_EN
        if (r_idx == 2'd3 && w_digit == 4'd0) w_seg_next = 8'h00;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_scan_cnt <= '0;
            r_idx      <= '0;
            r_an       <= 4'b0001;
            r_seg      <= 8'h3F;
        end else begin
            if (r_scan_cnt == SCAN_LAST) begin
                r_scan_cnt <= '0;
                r_idx      <= r_idx + 2'd1;
            end else begin
                r_scan_cnt <= r_scan_cnt + 20'd1;
            end
            r_an  <= 4'b0001 << r_idx;
            r_seg <= w_seg_next;
        end
    end

    assign bus.an  = r_an;
    assign bus.seg = r_seg;
    assign bus.ovf = r_ovf;

endmodule

// File: tb/tb_time_display.sv
// Scoreboard bench for time_display: expected MM:SS segment images are queued
// when Time is driven and compared once the conversion completes and digits are scanned.
module tb_time_display;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;
    logic [32:0] exp_q [$];

    time_display_if bus ();

    time_display #(.SCAN_DIV(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200us;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] seg_of(input int unsigned d);
        case (d)
            0: return 8'h3F;  1: return 8'h06;  2: return 8'h5B;  3: return 8'h4F;
            4: return 8'h66;  5: return 8'h6D;  6: return 8'h7D;  7: return 8'h07;
            8: return 8'h7F;  9: return 8'h6F;  default: return 8'hxx;
        endcase
    endfunction

    // {ovf, seg digit3, seg digit2, seg digit1, seg digit0}
    function automatic logic [32:0] expect_of(input int unsigned t);
        int unsigned m = t / 60;
        int unsigned s = t % 60;
        logic        ov = 1'b0;
        logic [7:0]  s3;
        if (m > 99) begin m = 99; s = 59; ov = 1'b1; end
        s3 = seg_of(m / 10);
`ifdef TIME_DISPLAY_LZB_EN
        if (m / 10 == 0) s3 = 8'h00;
`endif
        return {ov, s3, seg_of(m % 10) | 8'h80, seg_of(s / 10), seg_of(s % 10)};
    endfunction

    // Waits for busy to rise, then counts cycles until it falls; optionally changes Time mid-way.
    task automatic wait_conversion(input int change_at, input logic [15:0] new_t, output int n);
        int w = 0;
        n = 0;
        while (bus.busy !== 1'b1 && w < 20) begin @(posedge clk); #1; w++; end
        if (bus.busy !== 1'b1) return;
        while (bus.busy === 1'b1 && n < 60) begin
            if (n == change_at) bus.Time = new_t;
            @(posedge clk); #1;
            n++;
        end
    endtask

    // Samples one full scan of the four digits; slots not seen stay X.
    task automatic collect(output logic [32:0] got);
        logic [3:0]  seen = '0;
        logic [31:0] segs = 'x;
        @(negedge clk);
        for (int i = 0; i < 40 && seen != 4'hF; i++) begin
            @(negedge clk);
            case (bus.an)
                4'b0001: begin segs[7:0]   = bus.seg; seen[0] = 1'b1; end
                4'b0010: begin segs[15:8]  = bus.seg; seen[1] = 1'b1; end
                4'b0100: begin segs[23:16] = bus.seg; seen[2] = 1'b1; end
                4'b1000: begin segs[31:24] = bus.seg; seen[3] = 1'b1; end
                default: ;
            endcase
        end
        got = {bus.ovf, segs};
    endtask

    task automatic test_reset;
        logic [3:0] prev;
        logic [7:0] seg_d2 = 'x;
        logic       bad_hot = 1'b0, bad_seq = 1'b0, bad_gap = 1'b0, busy_seen = 1'b0;
        int         last_chg = -1, n_chg = 0;
        rst = 1'b1;
        bus.Time = 16'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if (bus.an !== 4'b0001) begin n_errors++; $display("FAIL reset_an got %b want 0001", bus.an); end
        n_checks++;
        if (bus.seg !== 8'h3F) begin n_errors++; $display("FAIL reset_seg got %h want 3f", bus.seg); end
        n_checks++;
        if ({bus.busy, bus.ovf} !== 2'b00) begin n_errors++; $display("FAIL reset_flags busy/ovf got %b want 00", {bus.busy, bus.ovf}); end
        prev = bus.an;
        for (int i = 0; i < 26; i++) begin
            @(negedge clk);
            if (bus.busy !== 1'b0) busy_seen = 1'b1;
            if (!$onehot(bus.an)) bad_hot = 1'b1;
            if (bus.an === 4'b0100) seg_d2 = bus.seg;
            if (bus.an !== prev) begin
                if (bus.an !== {prev[2:0], prev[3]}) bad_seq = 1'b1;
                if (n_chg > 0 && i - last_chg != 4) bad_gap = 1'b1;
                last_chg = i;
                n_chg++;
                prev = bus.an;
            end
        end
        n_checks++;
        if (bad_hot) begin n_errors++; $display("FAIL scan_onehot got non-one-hot an want one-hot"); end
        n_checks++;
        if (bad_seq || n_chg < 5) begin n_errors++; $display("FAIL scan_order got %0d steps bad=%b want >=5 rotating", n_chg, bad_seq); end
        n_checks++;
        if (bad_gap) begin n_errors++; $display("FAIL scan_period got irregular want 4 clocks"); end
        n_checks++;
        if (seg_d2 !== 8'hBF) begin n_errors++; $display("FAIL colon_dp got %h want bf", seg_d2); end
        n_checks++;
        if (busy_seen) begin n_errors++; $display("FAIL idle_busy got 1 want 0"); end
    endtask

    task automatic test_convert(input logic [15:0] t, input string name);
        int n;
        logic [32:0] got, exp;
        @(negedge clk);
        bus.Time = t;
        exp_q.push_back(expect_of(t));
        wait_conversion(-1, 16'd0, n);
        n_checks++;
        if (n != 25) begin n_errors++; $display("FAIL %s_busy got %0d want 25", name, n); end
        collect(got);
        exp = exp_q.pop_front();
        n_checks++;
        if (got !== exp) begin n_errors++; $display("FAIL %s_disp got %h want %h", name, got, exp); end
    endtask

    task automatic test_clamp;
        test_convert(16'd6000, "clamp6000");
        test_convert(16'd65535, "clamp65535");
    endtask

    task automatic test_reset_mid;
        int n = 0;
        logic [32:0] got, exp;
        @(negedge clk);
        bus.Time = 16'd754;
        while (bus.busy !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
        repeat (20) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({bus.an, bus.seg, bus.busy, bus.ovf} !== {4'b0001, 8'h3F, 2'b00})
            begin n_errors++; $display("FAIL midrst_vals got an=%b seg=%h busy=%b ovf=%b want 0001 3f 0 0", bus.an, bus.seg, bus.busy, bus.ovf); end
        @(negedge clk);
        rst = 1'b0;
        exp_q.push_back(expect_of(16'd754));
        wait_conversion(-1, 16'd0, n);
        n_checks++;
        if (n != 25) begin n_errors++; $display("FAIL midrst_busy got %0d want 25", n); end
        collect(got);
        exp = exp_q.pop_front();
        n_checks++;
        if (got !== exp) begin n_errors++; $display("FAIL midrst_disp got %h want %h", got, exp); end
    endtask

    task automatic test_back_to_back;
        int n;
        logic [32:0] got, exp;
        @(negedge clk);
        bus.Time = 16'd59;
        exp_q.push_back(expect_of(16'd59));
        exp_q.push_back(expect_of(16'd60));
        wait_conversion(5, 16'd60, n);
        n_checks++;
        if (n != 25) begin n_errors++; $display("FAIL b2b_first_busy got %0d want 25", n); end
        @(posedge clk); #1;
        n_checks++;
        if (bus.busy !== 1'b1) begin n_errors++; $display("FAIL b2b_restart got busy=%b want 1", bus.busy); end
        collect(got);
        exp = exp_q.pop_front();
        n_checks++;
        if (got !== exp) begin n_errors++; $display("FAIL b2b_first_disp got %h want %h", got, exp); end
        wait_conversion(-1, 16'd0, n);
        n_checks++;
        if (n == 0 || bus.busy !== 1'b0) begin n_errors++; $display("FAIL b2b_second_done got n=%0d busy=%b want done", n, bus.busy); end
        collect(got);
        exp = exp_q.pop_front();
        n_checks++;
        if (got !== exp) begin n_errors++; $display("FAIL b2b_second_disp got %h want %h", got, exp); end
    endtask

    task automatic test_lzb;
        test_convert(16'd65, "lzb65");
    endtask

    initial begin
        bus.Time = 16'd0;
        test_reset();
        test_convert(16'd754, "t754");
        test_clamp();
        test_reset_mid();
        test_convert(16'd5999, "t5999");
        test_back_to_back();
        test_lzb();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
